// File: rtl/ctr_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : ctr_bank_if
// Purpose  : Command/read bundle for the ctr_bank counter bank.
//            OvfVec is present only when CTR_BANK_STICKY_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ctr_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                WriteEn;
  logic [SELW-1:0]     WrSel;
  logic [WIDTH-1:0]    ValIn;
  logic                StepEn;
  logic [SELW-1:0]     StepSel;
  logic                StepDir;
  logic [SELW-1:0]     RdSel;
  logic [WIDTH-1:0]    ValOut;
  logic [CHANNELS-1:0] ZeroVec;
  logic                TcPulse;
`ifdef CTR_BANK_STICKY_OVF_EN
  logic [CHANNELS-1:0] OvfVec;
`endif

  modport master (
    output WriteEn, WrSel, ValIn, StepEn, StepSel, StepDir, RdSel,
`ifdef CTR_BANK_STICKY_OVF_EN
    input  OvfVec,
`endif
    input  ValOut, ZeroVec, TcPulse
  );

  modport slave (
    input  WriteEn, WrSel, ValIn, StepEn, StepSel, StepDir, RdSel,
`ifdef CTR_BANK_STICKY_OVF_EN
    output OvfVec,
`endif
    output ValOut, ZeroVec, TcPulse
  );
endinterface
`default_nettype wire

// File: rtl/ctr_bank.sv
`default_nettype none
// ============================================================================
// Module   : ctr_bank
// Purpose  : Bank of loadable up/down counters with wrap/saturate, zero flags
//            and terminal-count pulse. Optional CTR_BANK_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ctr_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SAT      = 0
) (
  input  wire logic  Clk,
  input  wire logic  Reset,
  ctr_bank_if.slave  bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    w_cnt [CHANNELS];
  logic [CHANNELS-1:0] w_evt;
  logic [WIDTH-1:0]    w_rd;
  logic                tc_q;
  logic                tc_d;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt_q;
      logic [WIDTH-1:0] cnt_d;
      logic             w_wr;
      logic             w_st;
      logic             w_bnd;

      // A load to the same channel overrides the step (and its boundary event).
      assign w_wr  = bus.WriteEn && (bus.WrSel == SELW'(i));
      assign w_st  = bus.StepEn && (bus.StepSel == SELW'(i)) && !w_wr;
      assign w_bnd = bus.StepDir ? (cnt_q == C_MAX) : (cnt_q == '0);
      assign w_evt[i] = w_st && w_bnd;

      always_comb begin
        cnt_d = cnt_q;
        if (w_wr) begin
          cnt_d = bus.ValIn;
        end else if (w_st) begin
          if (w_bnd && (SAT != 0)) begin
            cnt_d = cnt_q;
          end else if (bus.StepDir) begin
            cnt_d = cnt_q + WIDTH'(1);
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign w_cnt[i]       = cnt_q;
      assign bus.ZeroVec[i] = (cnt_q == '0);

`ifdef CTR_BANK_STICKY_OVF_EN
      logic ovf_q;
      logic ovf_d;

      always_comb begin
        ovf_d = ovf_q;
        if (w_wr) begin
          ovf_d = 1'b0;
        end else if (w_evt[i]) begin
          ovf_d = 1'b1;
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign bus.OvfVec[i] = ovf_q;
`endif
    end
  endgenerate

  // Unmatched (out-of-range) read selects fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.RdSel == SELW'(k)) begin
        w_rd = w_cnt[k];
      end
    end
  end

  assign bus.ValOut = w_rd;

  assign tc_d = |w_evt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign bus.TcPulse = tc_q;
endmodule
`default_nettype wire

// File: tb/tb_ctr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctr_bank
// Purpose  : Self-checking bench: DUT A (SAT=0, 4 ch) and DUT B (SAT=1, 3 ch)
//            share stimulus; checked by vector table, sequences and a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctr_bank;
  logic       Clk;
  logic       t_rst;
  logic       t_we;
  logic [1:0] t_ws;
  logic [7:0] t_vi;
  logic       t_se;
  logic [1:0] t_ss;
  logic       t_dir;
  logic [1:0] t_rs;

  int n_cmp = 0;
  int n_bad = 0;

  ctr_bank_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
  ctr_bank_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

  assign ifa.WriteEn = t_we;  assign ifb.WriteEn = t_we;
  assign ifa.WrSel   = t_ws;  assign ifb.WrSel   = t_ws;
  assign ifa.ValIn   = t_vi;  assign ifb.ValIn   = t_vi;
  assign ifa.StepEn  = t_se;  assign ifb.StepEn  = t_se;
  assign ifa.StepSel = t_ss;  assign ifb.StepSel = t_ss;
  assign ifa.StepDir = t_dir; assign ifb.StepDir = t_dir;
  assign ifa.RdSel   = t_rs;  assign ifb.RdSel   = t_rs;

  ctr_bank #(.WIDTH(8), .CHANNELS(4), .SAT(0)) u_dut_a (
    .Clk(Clk), .Reset(t_rst), .bus(ifa.slave));
  ctr_bank #(.WIDTH(8), .CHANNELS(3), .SAT(1)) u_dut_b (
    .Clk(Clk), .Reset(t_rst), .bus(ifb.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: index 0 = DUT A, index 1 = DUT B.
  int m_cnt [2][4];
  bit m_tc  [2];
  bit m_ovf [2][4];
  int m_nch [2] = '{4, 3};
  int m_sat [2] = '{0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_edge();
    for (int k = 0; k < 2; k++) begin
      if (t_rst) begin
        m_tc[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin m_cnt[k][c] = 0; m_ovf[k][c] = 1'b0; end
      end else begin
        m_tc[k] = 1'b0;
        for (int c = 0; c < m_nch[k]; c++) begin
          if (t_we && int'(t_ws) == c) begin
            m_cnt[k][c] = int'(t_vi);
            m_ovf[k][c] = 1'b0;
          end else if (t_se && int'(t_ss) == c) begin
            int nv;
            nv = m_cnt[k][c] + (t_dir ? 1 : -1);
            if (nv < 0 || nv > 255) begin
              m_tc[k] = 1'b1;
              m_ovf[k][c] = 1'b1;
              nv = (m_sat[k] != 0) ? m_cnt[k][c] : (nv + 256) % 256;
            end
            m_cnt[k][c] = nv;
          end
        end
      end
    end
  endtask

  task automatic mdl_check();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ev, ez, eo, av, az, at, ao;
      ev = (int'(t_rs) < m_nch[k]) ? 32'(m_cnt[k][t_rs]) : 32'd0;
      ez = '0; eo = '0;
      for (int c = 0; c < m_nch[k]; c++) begin
        ez[c] = (m_cnt[k][c] == 0);
        eo[c] = m_ovf[k][c];
      end
      av = (k == 0) ? 32'(ifa.ValOut)  : 32'(ifb.ValOut);
      az = (k == 0) ? 32'(ifa.ZeroVec) : 32'(ifb.ZeroVec);
      at = (k == 0) ? 32'(ifa.TcPulse) : 32'(ifb.TcPulse);
      chk($sformatf("model_val[%0d] rs=%0d", k, t_rs), av, ev);
      chk($sformatf("model_zero[%0d]", k), az, ez);
      chk($sformatf("model_tc[%0d]", k), at, 32'(m_tc[k]));
`ifdef CTR_BANK_STICKY_OVF_EN
      ao = (k == 0) ? 32'(ifa.OvfVec) : 32'(ifb.OvfVec);
      chk($sformatf("model_ovf[%0d]", k), ao, eo);
`else
      ao = eo;
`endif
    end
  endtask

  task automatic apply(input bit r, input bit we, input logic [1:0] ws, input logic [7:0] vi,
                       input bit se, input logic [1:0] ss, input bit dir, input logic [1:0] rs);
    t_rst = r; t_we = we; t_ws = ws; t_vi = vi;
    t_se = se; t_ss = ss; t_dir = dir; t_rs = rs;
    #1;
    mdl_check();
  endtask

  task automatic adv();
    @(posedge Clk);
    mdl_edge();
    @(negedge Clk);
  endtask

  typedef struct {
    bit r; bit we; logic [1:0] ws; logic [7:0] vi;
    bit se; logic [1:0] ss; bit dir; logic [1:0] rs;
    logic [7:0] ev; logic [3:0] ez; bit et; bit ct;
  } vec_t;

  function automatic vec_t V(bit r, bit we, logic [1:0] ws, logic [7:0] vi, bit se,
                             logic [1:0] ss, bit dir, logic [1:0] rs,
                             logic [7:0] ev, logic [3:0] ez, bit et, bit ct);
    vec_t v;
    v.r = r; v.we = we; v.ws = ws; v.vi = vi; v.se = se; v.ss = ss; v.dir = dir;
    v.rs = rs; v.ev = ev; v.ez = ez; v.et = et; v.ct = ct;
    return v;
  endfunction

  vec_t tbl [29];

  initial begin
    // Expected values are the outputs seen in the row's cycle, before its edge.
    tbl[0]  = V(0,1,0,8'h55,0,0,0,0, 8'h00,4'hF,0,1);
    tbl[1]  = V(0,1,1,8'h55,0,0,0,0, 8'h55,4'hE,0,1);
    tbl[2]  = V(0,1,2,8'h55,0,0,0,1, 8'h55,4'hC,0,1);
    tbl[3]  = V(0,1,3,8'h55,0,0,0,2, 8'h55,4'h8,0,1);
    tbl[4]  = V(1,0,0,8'h00,0,0,0,3, 8'h55,4'h0,0,1);
    tbl[5]  = V(0,0,0,8'h00,0,0,0,0, 8'h00,4'hF,0,1);
    tbl[6]  = V(0,0,0,8'h00,0,0,0,1, 8'h00,4'hF,0,1);
    tbl[7]  = V(0,0,0,8'h00,0,0,0,2, 8'h00,4'hF,0,1);
    tbl[8]  = V(0,0,0,8'h00,0,0,0,3, 8'h00,4'hF,0,1);
    tbl[9]  = V(0,1,2,8'h03,0,0,0,2, 8'h00,4'hF,0,1);
    tbl[10] = V(0,0,0,8'h00,1,2,0,2, 8'h03,4'hB,0,1);
    tbl[11] = V(0,0,0,8'h00,1,2,0,2, 8'h02,4'hB,0,1);
    tbl[12] = V(0,0,0,8'h00,1,2,0,2, 8'h01,4'hB,0,1);
    tbl[13] = V(0,0,0,8'h00,1,2,0,2, 8'h00,4'hF,0,1);
    tbl[14] = V(0,0,0,8'h00,0,0,0,2, 8'hFF,4'hB,1,1);
    tbl[15] = V(0,0,0,8'h00,0,0,0,2, 8'hFF,4'hB,0,1);
    tbl[16] = V(0,1,3,8'h07,0,0,0,0, 8'h00,4'hB,0,1);
    tbl[17] = V(0,1,0,8'h10,1,0,1,0, 8'h00,4'h3,0,1);
    tbl[18] = V(0,1,0,8'h10,1,3,1,0, 8'h10,4'h2,0,1);
    tbl[19] = V(0,0,0,8'h00,0,0,0,3, 8'h08,4'h2,0,1);
    tbl[20] = V(0,1,0,8'h20,0,0,0,0, 8'h10,4'h2,0,1);
    tbl[21] = V(0,0,0,8'h00,0,0,0,0, 8'h20,4'h2,0,1);
    tbl[22] = V(0,1,1,8'hFF,0,0,0,1, 8'h00,4'h2,0,1);
    tbl[23] = V(1,0,0,8'h00,1,1,1,1, 8'hFF,4'h0,0,1);
    tbl[24] = V(0,0,0,8'h00,0,0,0,1, 8'h00,4'hF,0,1);
    tbl[25] = V(0,1,1,8'hFF,0,0,0,1, 8'h00,4'hF,0,1);
    tbl[26] = V(0,0,0,8'h00,1,1,1,1, 8'hFF,4'hD,0,1);
    tbl[27] = V(1,0,0,8'h00,0,0,0,1, 8'h00,4'hF,0,0);
    tbl[28] = V(0,0,0,8'h00,0,0,0,1, 8'h00,4'hF,0,1);

    t_rst = 1'b1; t_we = 1'b0; t_ws = '0; t_vi = '0;
    t_se = 1'b0; t_ss = '0; t_dir = 1'b0; t_rs = '0;
    repeat (2) @(posedge Clk);
    mdl_edge();
    @(negedge Clk);

    for (int i = 0; i < 29; i++) begin
      apply(tbl[i].r, tbl[i].we, tbl[i].ws, tbl[i].vi, tbl[i].se, tbl[i].ss, tbl[i].dir, tbl[i].rs);
      chk($sformatf("tbl%0d_val", i), 32'(ifa.ValOut), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_zero", i), 32'(ifa.ZeroVec), 32'(tbl[i].ez));
      if (tbl[i].ct) chk($sformatf("tbl%0d_tc", i), 32'(ifa.TcPulse), 32'(tbl[i].et));
      adv();
    end

    // Saturating DUT B: FE stepped up three times.
    apply(0,1,1,8'hFE,0,0,0,1); adv();
    apply(0,0,0,8'h00,1,1,1,1); chk("sat_v0", 32'(ifb.ValOut), 32'hFE); adv();
    apply(0,0,0,8'h00,1,1,1,1); chk("sat_v1", 32'(ifb.ValOut), 32'hFF);
                                chk("sat_tc1", 32'(ifb.TcPulse), 32'd0); adv();
    apply(0,0,0,8'h00,1,1,1,1); chk("sat_v2", 32'(ifb.ValOut), 32'hFF);
                                chk("sat_tc2", 32'(ifb.TcPulse), 32'd1); adv();
    apply(0,0,0,8'h00,0,0,0,1); chk("sat_v3", 32'(ifb.ValOut), 32'hFF);
                                chk("sat_tc3", 32'(ifb.TcPulse), 32'd1); adv();
    apply(0,0,0,8'h00,0,0,0,1); chk("sat_tc4", 32'(ifb.TcPulse), 32'd0); adv();
    // Out-of-range write/step/read on the 3-channel DUT.
    apply(0,1,3,8'h77,1,3,1,3); chk("oor_rd", 32'(ifb.ValOut), 32'd0); adv();
    apply(0,0,0,8'h00,0,0,0,3); chk("oor_rd2", 32'(ifb.ValOut), 32'd0);
                                chk("oor_tc", 32'(ifb.TcPulse), 32'd0); adv();

`ifdef CTR_BANK_STICKY_OVF_EN
    apply(0,1,3,8'hFF,0,0,0,3); adv();
    apply(0,0,0,8'h00,1,3,1,3); chk("ovf_pre", 32'(ifa.OvfVec[3]), 32'd0); adv();
    for (int i = 0; i < 5; i++) begin
      apply(0,0,0,8'h00,0,0,0,3);
      chk($sformatf("ovf_hold%0d", i), 32'(ifa.OvfVec[3]), 32'd1);
      adv();
    end
    apply(0,1,3,8'h01,0,0,0,3); chk("ovf_ld", 32'(ifa.OvfVec[3]), 32'd1); adv();
    apply(0,0,0,8'h00,0,0,0,3); chk("ovf_clr", 32'(ifa.OvfVec[3]), 32'd0); adv();
`endif

    // Random traffic, values biased toward the boundaries.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] vi;
      case ($urandom_range(0, 4))
        0: vi = 8'h00;
        1: vi = 8'hFF;
        2: vi = 8'hFE;
        3: vi = 8'h01;
        default: vi = 8'($urandom);
      endcase
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), 2'($urandom), vi,
            ($urandom_range(0, 9) < 7), 2'($urandom), 1'($urandom), 2'($urandom));
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
